// File: rtl/pulse_burst_arbiter.sv
// pulse_burst_arbiter
//
// Shares one decade-style pulse counter among NUM_REQ requesters. The counter
// is handed out by round-robin arbitration. The owner feeds qualifying pulses
// until TERM_CNT have been counted. On the terminal pulse the owner receives a
// one-cycle done strobe and the block raises a one-cycle op_sig.
//
// State table:
//   IDLE    | no owner; arbitrate among set req bits on each edge
//   COUNT   | owner holds the counter; pulse_in advances count
//   RELEASE | single cycle with done/op_sig high, then back to IDLE
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   req          level request per requester (drop to abort)
//   pulse_in     qualifying pulse, counted while in COUNT
//   grant        one-hot owner of the counter, zero outside COUNT
//   busy         high in COUNT and RELEASE
//   count        pulse count of the active burst
//   done         one-cycle strobe to the owner on burst completion
//   op_sig       one-cycle strobe on burst completion
//   timeout_err  one-cycle strobe on watchdog abort
//
// Optional feature, macro PULSE_BURST_TIMEOUT_EN:
//   Defined     - an idle watchdog aborts the burst after TIMEOUT_CYC
//                 consecutive COUNT cycles without pulse_in and pulses
//                 timeout_err.
//   Not defined - no watchdog; timeout_err is tied low.

module pulse_burst_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TERM_CNT    = 10,
    parameter int CNT_W       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               pulse_in,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy,
    output logic [CNT_W-1:0]   count,
    output logic [NUM_REQ-1:0] done,
    output logic               op_sig,
    output logic               timeout_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TERM_CNT - 1);
    localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TERM_CNT < 2 || TERM_CNT > 2**CNT_W
        || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("pulse_burst_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COUNT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   last_q, last_d;
    logic [NUM_REQ-1:0] grant_d;
    logic               busy_d;
    logic [CNT_W-1:0]   count_d;
    logic [NUM_REQ-1:0] done_d;
    logic               op_d;

    logic               win_found;
    logic [PTR_W-1:0]   win_idx;

`ifdef PULSE_BURST_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic               to_d;
`endif

    // Round-robin search starting just after the previous winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!win_found && req[(int'(last_q) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'((int'(last_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant;
        busy_d  = busy;
        count_d = count;
        done_d  = '0;
        op_d    = 1'b0;
`ifdef PULSE_BURST_TIMEOUT_EN
        idle_d  = idle_q;
        to_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_COUNT;
                    last_d  = win_idx;
                    grant_d = NUM_REQ'(1) << win_idx;
                    count_d = '0;
                    busy_d  = 1'b1;
`ifdef PULSE_BURST_TIMEOUT_EN
                    idle_d  = '0;
`endif
                end
            end
            S_COUNT: begin
                // Owner dropping its request wins over a terminal pulse.
                if (!req[last_q]) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    count_d = '0;
                end
`ifdef PULSE_BURST_TIMEOUT_EN
                else if (!pulse_in && idle_q == IDLE_LAST) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    count_d = '0;
                    to_d    = 1'b1;
                end
`endif
                else if (pulse_in) begin
`ifdef PULSE_BURST_TIMEOUT_EN
                    idle_d = '0;
`endif
                    if (count == CNT_LAST) begin
                        state_d = S_RELEASE;
                        count_d = '0;
                        grant_d = '0;
                        op_d    = 1'b1;
                        done_d  = NUM_REQ'(1) << last_q;
                    end else begin
                        count_d = count + 1'b1;
                    end
                end
`ifdef PULSE_BURST_TIMEOUT_EN
                else begin
                    idle_d = idle_q + 1'b1;
                end
`endif
            end
            S_RELEASE: begin
                state_d = S_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            last_q  <= PTR_RST;
            grant   <= '0;
            busy    <= 1'b0;
            count   <= '0;
            done    <= '0;
            op_sig  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant   <= grant_d;
            busy    <= busy_d;
            count   <= count_d;
            done    <= done_d;
            op_sig  <= op_d;
        end
    end

`ifdef PULSE_BURST_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_q      <= '0;
            timeout_err <= 1'b0;
        end else begin
            idle_q      <= idle_d;
            timeout_err <= to_d;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule
